piso_stream: RTL and testbench

Parametrised parallel-in/serial-out shift register, the successor to the fixed 4-bit left-shifting PISO. It accepts WIDTH-bit words over a valid/ready handshake and serialises each word MSB-first or LSB-first, with the order chosen per word. A shift_en input stalls the shift, and a word can be reloaded on the last bit of the previous one, giving a gap-free serial stream. It drives serial links such as SPI/UART-style transmitters in the sequential-circuits library.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_stream_if.sv | 27 ++
 rtl/piso_bit_cnt.sv | 37 +++
 rtl/piso_stream.sv | 97 +++++++++
 tb/tb_piso_stream.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_stream serialiser.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_stream_if.sv
// Parallel-word handshake and serial-side signals of piso_stream.
interface piso_stream_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] pin;
    logic             pin_valid;
    logic             pin_ready;
    logic             lsb_first;
    logic             shift_en;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             sout_valid;
    logic             last;
    logic             busy;

    modport master (
        output pin, pin_valid, lsb_first, shift_en,
        input  pin_ready, q, sout, sout_valid, last, busy
    );

    modport slave (
        input  pin, pin_valid, lsb_first, shift_en,
        output pin_ready, q, sout, sout_valid, last, busy
    );

endinterface

// File: rtl/piso_bit_cnt.sv
// Frame bit counter: clears on a new word or frame end, saturates at WIDTH-1.
module piso_bit_cnt #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign tc_o  = (cnt_q == CNT_W'(WIDTH - 1));
    assign cnt_o = cnt_q;

    // Saturate rather than wrap so the count can never run past the frame.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with per-word bit order, stall and
// gap-free reload on the final bit of a frame.
module piso_stream
    import piso_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  logic        FILL  = 1'b0,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    piso_stream_if.slave  bus
);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_stream: WIDTH must be at least 2");
    end

    piso_state_e      st_d, st_q;
    logic [WIDTH-1:0] q_d, q_q;
    logic             dir_d, dir_q;

    logic             in_shift;
    logic             tc;
    logic             last;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt;

    assign in_shift = (st_q == SHIFT);
    assign last     = in_shift && tc;
    assign accept   = bus.pin_valid && bus.pin_ready;
    assign cnt_clr  = accept || (last && bus.shift_en);
    assign cnt_en   = in_shift && bus.shift_en;

    assign bus.pin_ready  = rst && (!in_shift || (last && bus.shift_en));
    assign bus.sout       = (dir_q == DIR_MSB_FIRST) ? q_q[WIDTH-1] : q_q[0];
    assign bus.sout_valid = in_shift;
    assign bus.busy       = in_shift;
    assign bus.last       = last;
    assign bus.q          = q_q;

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    // A new word wins over the shift on the last bit, keeping the stream contiguous.
    always_comb begin
        st_d  = st_q;
        q_d   = q_q;
        dir_d = dir_q;
        if (accept) begin
            q_d   = bus.pin;
            dir_d = bus.lsb_first;
            st_d  = SHIFT;
        end else if (in_shift && bus.shift_en) begin
            if (dir_q == DIR_LSB_FIRST) begin
                q_d = {FILL, q_q[WIDTH-1:1]};
            end else begin
                q_d = {q_q[WIDTH-2:0], FILL};
            end
            if (tc) begin
                st_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= IDLE;
            q_q   <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else begin
            st_q  <= st_d;
            q_q   <= q_d;
            dir_q <= dir_d;
        end
    end

    a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst)
        cnt <= CNT_W'(WIDTH - 1));

    a_idle_cnt_zero: assert property (@(posedge clk) disable iff (!rst)
        (st_q == IDLE) |-> (cnt == '0));

    a_stall_holds: assert property (@(posedge clk) disable iff (!rst)
        (in_shift && !bus.shift_en) |=> (q_q == $past(q_q) && st_q == SHIFT));

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench: a vector table for single, LSB-first and back-to-back frames,
// then hand sequences for stall, asynchronous reset and FILL=1.
module tb_piso_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_stream_if #(.WIDTH(4)) bus4 ();
    piso_stream_if #(.WIDTH(8)) bus8 ();

    piso_stream #(.WIDTH(4), .FILL(1'b0)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    piso_stream #(.WIDTH(8), .FILL(1'b1)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] pin;
        logic       valid;
        logic       lsb;
        logic       sh;
        logic [3:0] q;
        logic       sout;
        logic       sv;
        logic       last;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int         busy_cyc;
        int         last_at;
        int         n;
        int         ones;
        logic [3:0] bits;

        // pin, valid, lsb, sh | q, sout, sv, last, busy, rdy
        vecs[0]  = '{4'hE, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{4'h0, 1'b0, 1'b0, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'h0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'h0, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{4'hE, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{4'h0, 1'b0, 1'b0, 1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'h0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{4'h0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{4'hA, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{4'h6, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{4'h6, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'h6, 1'b1, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'h6, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{4'h0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{4'h0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{4'h0, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b0;
        bus4.pin = '0; bus4.pin_valid = 1'b0; bus4.lsb_first = 1'b0; bus4.shift_en = 1'b0;
        bus8.pin = '0; bus8.pin_valid = 1'b0; bus8.lsb_first = 1'b0; bus8.shift_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.q4", 32'(bus4.q), 32'h0);
        chk("rst.sv4", 32'(bus4.sout_valid), 32'h0);
        chk("rst.busy4", 32'(bus4.busy), 32'h0);
        chk("rst.last4", 32'(bus4.last), 32'h0);
        chk("rst.sout4", 32'(bus4.sout), 32'h0);
        chk("rst.rdy4", 32'(bus4.pin_ready), 32'h0);
        chk("rst.q8", 32'(bus8.q), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus4.pin       = vecs[i].pin;
            bus4.pin_valid = vecs[i].valid;
            bus4.lsb_first = vecs[i].lsb;
            bus4.shift_en  = vecs[i].sh;
            #1;
            chk($sformatf("v%0d.q", i), 32'(bus4.q), 32'(vecs[i].q));
            chk($sformatf("v%0d.sout", i), 32'(bus4.sout), 32'(vecs[i].sout));
            chk($sformatf("v%0d.sout_valid", i), 32'(bus4.sout_valid), 32'(vecs[i].sv));
            chk($sformatf("v%0d.last", i), 32'(bus4.last), 32'(vecs[i].last));
            chk($sformatf("v%0d.busy", i), 32'(bus4.busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d.pin_ready", i), 32'(bus4.pin_ready), 32'(vecs[i].rdy));
        end

        // Stall for 3 cycles on bit 2 of 1110 while a word is offered.
        @(negedge clk);
        bus4.pin = 4'hE; bus4.pin_valid = 1'b1; bus4.lsb_first = 1'b0; bus4.shift_en = 1'b1;
        #1;
        chk("stall.accept_rdy", 32'(bus4.pin_ready), 32'h1);
        @(negedge clk);
        busy_cyc = 0;
        last_at  = -1;
        for (int i = 0; i < 20 && last_at < 0; i++) begin
            bus4.shift_en  = !(i >= 1 && i <= 3);
            bus4.pin_valid = (i >= 1 && i <= 3);
            bus4.pin       = 4'h5;
            #1;
            if (bus4.busy) busy_cyc++;
            if (i >= 1 && i <= 3) begin
                chk($sformatf("stall%0d.sout", i), 32'(bus4.sout), 32'h1);
                chk($sformatf("stall%0d.q", i), 32'(bus4.q), 32'hC);
                chk($sformatf("stall%0d.rdy", i), 32'(bus4.pin_ready), 32'h0);
                chk($sformatf("stall%0d.last", i), 32'(bus4.last), 32'h0);
            end
            if (bus4.last) last_at = i;
            @(negedge clk);
        end
        chk("stall.last_cycle", 32'(last_at), 32'd6);
        chk("stall.frame_cycles", 32'(busy_cyc), 32'd7);
        #1;
        chk("stall.idle_busy", 32'(bus4.busy), 32'h0);
        chk("stall.idle_q", 32'(bus4.q), 32'h0);

        // Asynchronous reset between edges after two bits of 1110.
        @(negedge clk);
        bus4.pin = 4'hE; bus4.pin_valid = 1'b1; bus4.lsb_first = 1'b0; bus4.shift_en = 1'b1;
        @(negedge clk);
        bus4.pin_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("arst.pre_q", 32'(bus4.q), 32'h8);
        #1;
        rst = 1'b0;
        #1;
        chk("arst.q", 32'(bus4.q), 32'h0);
        chk("arst.sv", 32'(bus4.sout_valid), 32'h0);
        chk("arst.busy", 32'(bus4.busy), 32'h0);
        chk("arst.rdy", 32'(bus4.pin_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst.rel_rdy", 32'(bus4.pin_ready), 32'h1);
        chk("arst.rel_sv", 32'(bus4.sout_valid), 32'h0);
        bus4.pin = 4'h5; bus4.pin_valid = 1'b1; bus4.lsb_first = 1'b0; bus4.shift_en = 1'b1;
        n    = 0;
        bits = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus4.pin_valid = 1'b0;
            #1;
            if (bus4.sout_valid && bus4.shift_en) begin
                bits = {bits[2:0], bus4.sout};
                n++;
            end
        end
        chk("arst.nbits", 32'(n), 32'd4);
        chk("arst.bits", 32'(bits), 32'h5);

        // FILL=1, WIDTH=8: an all-zero word leaves q all ones.
        @(negedge clk);
        bus8.pin = 8'h00; bus8.pin_valid = 1'b1; bus8.lsb_first = 1'b0; bus8.shift_en = 1'b1;
        n    = 0;
        ones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus8.pin_valid = 1'b0;
            #1;
            if (bus8.sout_valid && bus8.shift_en) begin
                if (n == 1) chk("fill.q_bit1", 32'(bus8.q), 32'h01);
                if (bus8.sout) ones++;
                n++;
            end
        end
        chk("fill.nbits", 32'(n), 32'd8);
        chk("fill.ones", 32'(ones), 32'd0);
        chk("fill.q_end", 32'(bus8.q), 32'hFF);
        chk("fill.idle_sv", 32'(bus8.sout_valid), 32'h0);
        chk("fill.idle_rdy", 32'(bus8.pin_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
